// File: rtl/rectify_pkg.sv
// rectify_pkg: shared defaults and FSM state encoding for the rectification neighbour fetch
package rectify_pkg;
  localparam int DEF_D_WIDTH = 6;
  localparam int DEF_IMG_W   = 640;
  localparam int DEF_IMG_H   = 480;
  localparam int DEF_X_W     = 10;
  localparam int DEF_Y_W     = 9;
  localparam int DEF_ADDR_W  = 19;
  typedef enum logic [2:0] {IDLE, RD_LU, RD_RU, RD_LD, RD_RD, CAP, OUT} state_t;
endpackage

// File: rtl/rectify_neighbor_fetch_addr.sv
// neighbor_addr_gen: linear base address and in-image flags of the 2x2 neighbourhood at (xi, yi)
// ports: xi_i/yi_i signed integer coordinate; base_o = yi*IMG_W+xi truncated; vld_o = {rd, ld, ru, lu}
module neighbor_addr_gen #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int ADDR_W = 19
) (
  input  logic signed [X_W:0]    xi_i,
  input  logic signed [Y_W:0]    yi_i,
  output logic [ADDR_W-1:0]      base_o,
  output logic [3:0]             vld_o
);
  logic signed [31:0] xs, ys;
  logic c0, c1, r0, r1;
  assign xs = 32'(xi_i);
  assign ys = 32'(yi_i);
  assign base_o = ADDR_W'(ys * IMG_W + xs);
  assign c0 = xs >= 0 && xs < IMG_W;
  assign c1 = xs >= -1 && xs < IMG_W - 1;
  assign r0 = ys >= 0 && ys < IMG_H;
  assign r1 = ys >= -1 && ys < IMG_H - 1;
  assign vld_o = {c1 & r1, c0 & r1, c1 & r0, c0 & r0};
endmodule

// File: rtl/rectify_neighbor_fetch.sv
// rectify_neighbor_fetch: fetches the 2x2 pixel neighbourhood of a source coordinate for bilinear interpolation
// ports: in_* request handshake/coordinate; mem_* single-cycle-latency pixel RAM read; out_*/dx/dy/lu/ru/ld/rd interpolator operands
module rectify_neighbor_fetch import rectify_pkg::*; #(
  parameter int D_width = DEF_D_WIDTH,
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [X_W:0] in_xi,
  input  logic signed [Y_W:0] in_yi,
  input  logic [D_width-1:0]  in_dx,
  input  logic [D_width-1:0]  in_dy,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [D_width-1:0]  dx,
  output logic [D_width-1:0]  dy,
  output logic [7:0]          lu,
  output logic [7:0]          ru,
  output logic [7:0]          ld,
  output logic [7:0]          rd,
  output logic                out_border
);
  state_t state_q, state_d;
  logic [D_width-1:0] dx_q, dy_q;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0] vld_q, vld_d;
  logic [3:0][7:0] px_q;
  logic border_q, accept, rd_slot, cap_en;
  logic [1:0] slot, cap;
  neighbor_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)
  ) u_addr (
    .xi_i(in_xi), .yi_i(in_yi), .base_o(base_d), .vld_o(vld_d)
  );
  assign accept = state_q == IDLE && in_valid;
  // slot = neighbour being read now; cap = neighbour whose data returns now
  always_comb begin
    state_d = state_q == IDLE ? (in_valid ? RD_LU : IDLE) :
              state_q == OUT  ? (out_ready ? IDLE : OUT) : state_t'(state_q + 3'd1);
    slot = 2'(state_q - RD_LU);
    cap = 2'(state_q - RD_RU);
    rd_slot = state_q >= RD_LU && state_q <= RD_RD;
    cap_en = state_q >= RD_RU && state_q <= CAP;
    mem_rd_en = rd_slot && vld_q[slot];
    mem_addr = mem_rd_en ? base_q + (slot[1] ? ADDR_W'(IMG_W) : '0) + ADDR_W'(slot[0]) : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dx_q <= '0;
      dy_q <= '0;
      base_q <= '0;
      vld_q <= '0;
      px_q <= '0;
      border_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dx_q <= in_dx;
        dy_q <= in_dy;
        base_q <= base_d;
        vld_q <= vld_d;
        border_q <= ~|vld_d;
      end
      if (cap_en) px_q[cap] <= vld_q[cap] ? mem_rdata : 8'd0;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == OUT;
  assign dx = dx_q;
  assign dy = dy_q;
  assign lu = px_q[0];
  assign ru = px_q[1];
  assign ld = px_q[2];
  assign rd = px_q[3];
  assign out_border = border_q;
endmodule

// File: tb/tb_rectify_neighbor_fetch.sv
// tb_rectify_neighbor_fetch: directed and randomized checks of the neighbour fetch against a coordinate-level model
module tb_rectify_neighbor_fetch;
  localparam int W = 640;
  localparam int H = 480;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_ready = 1'b1;
  logic signed [10:0] in_xi = '0;
  logic signed [9:0] in_yi = '0;
  logic [5:0] in_dx = '0, in_dy = '0, dx, dy;
  logic mem_rd_en, out_valid, out_border;
  logic [18:0] mem_addr;
  logic [7:0] mem_rdata = '0, lu, ru, ld, rd, salt;
  int checks = 0, errors = 0;
  rectify_neighbor_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_xi(in_xi), .in_yi(in_yi), .in_dx(in_dx), .in_dy(in_dy),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .dx(dx), .dy(dy),
    .lu(lu), .ru(ru), .ld(ld), .rd(rd), .out_border(out_border)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] pix(int a);
    return 8'(a * 37 + (a >> 7)) ^ salt;
  endfunction
  always @(posedge clk) mem_rdata <= mem_rd_en ? pix(int'(mem_addr)) : 8'($urandom);
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(logic [7:0] ep[4], int edx, int edy, bit eb);
    chk("out_valid", 32'(out_valid), 1);
    chk("in_ready_out", 32'(in_ready), 0);
    chk("lu", 32'(lu), 32'(ep[0]));
    chk("ru", 32'(ru), 32'(ep[1]));
    chk("ld", 32'(ld), 32'(ep[2]));
    chk("rd", 32'(rd), 32'(ep[3]));
    chk("dx", 32'(dx), 32'(edx));
    chk("dy", 32'(dy), 32'(edy));
    chk("border", 32'(out_border), 32'(eb));
  endtask
  task automatic req(int xi, int yi, int edx, int edy, int bp);
    logic [7:0] ep[4];
    bit ev[4];
    int ea[4];
    for (int k = 0; k < 4; k++) begin
      int col = xi + k % 2;
      int row = yi + k / 2;
      ev[k] = col >= 0 && col < W && row >= 0 && row < H;
      ea[k] = ev[k] ? row * W + col : 0;
      ep[k] = ev[k] ? pix(ea[k]) : 8'd0;
    end
    in_xi = 11'(xi);
    in_yi = 10'(yi);
    in_dx = 6'(edx);
    in_dy = 6'(edy);
    in_valid = 1'b1;
    out_ready = bp == 0;
    chk("in_ready_idle", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rd_en", 32'(mem_rd_en), 32'(ev[k]));
      chk("addr", 32'(mem_addr), 32'(ea[k]));
      chk("ov_fetch", 32'(out_valid), 0);
      @(posedge clk); #1;
    end
    chk("ov_cap", 32'(out_valid), 0);
    @(posedge clk); #1;
    for (int c = 0; c <= bp; c++) begin
      chk_out(ep, edx, edy, !(ev[0] | ev[1] | ev[2] | ev[3]));
      if (c == bp) out_ready = 1'b1;
      @(posedge clk); #1;
    end
    chk("ov_done", 32'(out_valid), 0);
    chk("in_ready_done", 32'(in_ready), 1);
  endtask
  initial begin
    int xs[10];
    int ys[10];
    salt = 8'($urandom);
    xs = '{-2, -1, 0, 1, W - 2, W - 1, W, W + 1, 1023, -1024};
    ys = '{-2, -1, 0, 1, H - 2, H - 1, H, H + 1, 511, -512};
    #12;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_px", {lu, ru, ld, rd}, 0);
    chk("rst_dxdy", 32'({dx, dy}), 0);
    chk("rst_border", 32'(out_border), 0);
    req(10, 20, 5, 9, 0);
    req(639, 0, 1, 2, 0);
    req(-1, 0, 63, 0, 0);
    req(700, 5, 7, 7, 0);
    req(100, 100, 33, 44, 3);
    in_xi = 11'(50);
    in_yi = 10'(60);
    in_dx = 6'd3;
    in_dy = 6'd4;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", 32'(out_valid), 0);
    chk("mid_rst_rd_en", 32'(mem_rd_en), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_px", {lu, ru, ld, rd}, 0);
    chk("mid_rst_dxdy", 32'({dx, dy}), 0);
    chk("mid_rst_border", 32'(out_border), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_no_ov", 32'(out_valid), 0);
      @(posedge clk); #1;
    end
    req(50, 60, 3, 4, 0);
    for (int i = 0; i < 40; i++) begin
      int x = $urandom_range(0, 1) ? int'($urandom_range(0, W - 1)) : xs[$urandom_range(0, 9)];
      int y = $urandom_range(0, 1) ? int'($urandom_range(0, H - 1)) : ys[$urandom_range(0, 9)];
      req(x, y, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
